// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
  localparam logic [WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;

  // Magnitude as unsigned; INT_MIN maps onto itself, which is the correct unsigned value.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem, quo} left, trial-subtract, keep or restore.
module div_step
  import div_pkg::*;
(
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH-1:0] w_rem_sh;
  logic [WIDTH-1:0] w_quo_sh;
  logic [WIDTH:0]   w_trial;

  // Remainder stays below the divisor (at most 2^31), so the shifted-out MSB is always 0.
  assign w_rem_sh = {i_rem[WIDTH-2:0], i_quo[WIDTH-1]};
  assign w_quo_sh = {i_quo[WIDTH-2:0], 1'b0};
  assign w_trial  = {1'b0, w_rem_sh} - {1'b0, i_divisor};

  // NOTE: every output gets a default first so always_comb can never infer a latch.
  always_comb begin
    o_rem = w_rem_sh;
    o_quo = w_quo_sh;
    if (!w_trial[WIDTH]) begin
      o_rem = w_trial[WIDTH-1:0];
      o_quo = {w_quo_sh[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed 32-bit divider: one restoring step per clock, truncating quotient.
module seq_divider
  import div_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_sign;
  logic               r_exc_pend;
  logic [WIDTH-1:0]   r_result;
  logic               r_exc;
  logic               r_rdy;
  logic               r_busy;

  logic [WIDTH-1:0]   w_next_rem;
  logic [WIDTH-1:0]   w_next_quo;
  logic [WIDTH-1:0]   w_fixed;
  logic               w_div_zero;
  logic               w_overflow;

  div_step u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_next_rem),
    .o_quo     (w_next_quo)
  );

  assign w_div_zero = (data_operandB == '0);
  assign w_overflow = (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
  assign w_fixed    = r_sign ? ((~r_quo) + WIDTH'(1)) : r_quo;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_divisor  <= '0;
      r_sign     <= 1'b0;
      r_exc_pend <= 1'b0;
      r_result   <= '0;
      r_exc      <= 1'b0;
      r_rdy      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rdy  <= 1'b0;
          r_busy <= ctrl_DIV;
          if (ctrl_DIV) begin
            r_count   <= '0;
            r_rem     <= '0;
            r_divisor <= abs_val(data_operandB);
            // Exception cases preload the final quotient and skip the iteration.
            if (w_div_zero) begin
              r_quo      <= '0;
              r_sign     <= 1'b0;
              r_exc_pend <= 1'b1;
              r_state    <= DONE;
            end else if (w_overflow) begin
              r_quo      <= INT_MIN;
              r_sign     <= 1'b0;
              r_exc_pend <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_quo      <= abs_val(data_operandA);
              r_sign     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
              r_exc_pend <= 1'b0;
              r_state    <= CALC;
            end
          end
        end

        CALC: begin
          r_rem   <= w_next_rem;
          r_quo   <= w_next_quo;
          r_count <= r_count + CNT_W'(1);
          if (r_count == CNT_W'(ITER - 1)) begin
            r_state <= DONE;
          end
        end

        DONE: begin
          // Results land with the RDY pulse; busy is held through that cycle.
          r_result <= w_fixed;
          r_exc    <= r_exc_pend;
          r_rdy    <= 1'b1;
          r_state  <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus ignored-start and reset-abort sequences.
module tb_seq_divider;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int bcnt   = 0;

  seq_divider dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
    int          lat;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Waits for RDY, counting edges and busy samples; lat = -1 on timeout.
  task automatic wait_rdy(output int lat);
    bit got;
    got = 0;
    lat = 0;
    while (!got && lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (busy) bcnt++;
      if (data_resultRDY) got = 1;
    end
    if (!got) lat = -1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    string nm;
    nm = $sformatf("vec%0d", idx);
    data_operandA = v.a;
    data_operandB = v.b;
    ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    bcnt = busy ? 1 : 0;
    wait_rdy(lat);
    check({nm, " latency"}, lat, v.lat);
    check({nm, " result"}, data_result, v.res);
    check({nm, " exception"}, {31'b0, data_exception}, {31'b0, v.exc});
    check({nm, " busy_cycles"}, bcnt, v.lat + 1);
    @(posedge clock); #1;
    check({nm, " rdy_drop"}, {31'b0, data_resultRDY}, 32'd0);
    check({nm, " busy_drop"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    vec_t vecs[12];
    int   lat;
    bit   saw_rdy;

    vecs[0]  = '{32'd100,       32'd7,         32'd14,        1'b0, 33};
    vecs[1]  = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  1'b0, 33};
    vecs[2]  = '{32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  1'b0, 33};
    vecs[3]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        1'b0, 33};
    vecs[4]  = '{32'd7,         32'd100,       32'd0,         1'b0, 33};
    vecs[5]  = '{32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  1'b0, 33};
    vecs[6]  = '{32'd5,         32'd0,         32'd0,         1'b1, 1};
    vecs[7]  = '{32'd6,         32'd3,         32'd2,         1'b0, 33};
    vecs[8]  = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b1, 1};
    vecs[9]  = '{32'h80000000,  32'd1,         32'h80000000,  1'b0, 33};
    vecs[10] = '{32'h7FFFFFFF,  32'd2,         32'h3FFFFFFF,  1'b0, 33};
    vecs[11] = '{32'h80000000,  32'h80000000,  32'd1,         1'b0, 33};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset result", data_result, 32'd0);
    check("reset exception", {31'b0, data_exception}, 32'd0);
    check("reset rdy", {31'b0, data_resultRDY}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Start ignored mid-calculation, then a back-to-back start on the first legal edge.
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (9) begin
      @(posedge clock); #1;
    end
    data_operandA = 32'd9;
    data_operandB = 32'd3;
    ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    wait_rdy(lat);
    check("ignored latency", lat, 32'd23);
    check("ignored result", data_result, 32'd14);
    check("ignored exception", {31'b0, data_exception}, 32'd0);
    ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    check("b2b rdy_drop", {31'b0, data_resultRDY}, 32'd0);
    check("b2b busy", {31'b0, busy}, 32'd1);
    wait_rdy(lat);
    check("b2b latency", lat, 32'd33);
    check("b2b result", data_result, 32'd3);
    @(posedge clock); #1;

    // Reset during CALC aborts without a RDY pulse.
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (15) begin
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    #1;
    check("abort result", data_result, 32'd0);
    check("abort exception", {31'b0, data_exception}, 32'd0);
    check("abort rdy", {31'b0, data_resultRDY}, 32'd0);
    check("abort busy", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    saw_rdy = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY || busy) saw_rdy = 1;
    end
    check("abort no_rdy", {31'b0, saw_rdy}, 32'd0);
    run_vec('{32'd50, 32'd5, 32'd10, 1'b0, 33}, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
